ymat_row_unpacker: RTL

Inverse of the Y-matrix row-to-SRAM address mapping: the SRAM address is the element row index divided by 16, so each SRAM word holds 16 consecutive element rows.
- Given a starting element row and a count, walks the element rows, issues one SRAM word read per 16-row group, and streams out each element together with its reconstructed element row index ({sram_addr, lane}).
- Sits between the Y-matrix SRAM and the downstream compute datapath.

---
 rtl/ymat_row_unpacker.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ymat_row_unpacker.sv
// Y-matrix row unpacker: reads 16-element SRAM words and streams each element with its row index.
// Optional YMR_PREFETCH_EN adds a second word buffer so word boundaries cost no bubble.
module ymat_row_unpacker #(
   parameter int ROW_W     = 11,
   parameter int LANE_LOG2 = 4,
   parameter int ELEM_W    = 16,
   parameter int ADDR_W    = ROW_W - LANE_LOG2
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           start,
   input  logic [ROW_W-1:0]               row_start,
   input  logic [ROW_W:0]                 row_count,
   output logic                           sram_rd_en,
   output logic [ADDR_W-1:0]              sram_addr,
   input  logic [(ELEM_W<<LANE_LOG2)-1:0] sram_rdata,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [ROW_W-1:0]               out_row,
   output logic [ELEM_W-1:0]              out_data,
   output logic                           busy,
   output logic                           done,
   output logic [2:0]                     dbgState
);

   localparam int WORD_W = ELEM_W << LANE_LOG2;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] READ   = 3'd1;
   localparam logic [2:0] WAIT   = 3'd2;
   localparam logic [2:0] UNPACK = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;

   // Handshake: an element transfers on any rising edge where out_valid and out_ready are both high;
   // out_row/out_data stay put until that happens.
   logic [2:0]           state;
   logic [ADDR_W-1:0]    addr;
   logic [LANE_LOG2-1:0] lane;
   logic [ROW_W:0]       remaining;
   logic [WORD_W-1:0]    wordBuf;
   logic                 accept;
   logic                 lastElem;
   logic                 lastLane;
   logic                 pfRead;

   assign accept   = (state == UNPACK) && out_ready;
   assign lastElem = (remaining == (ROW_W+1)'(1));
   assign lastLane = (lane == {LANE_LOG2{1'b1}});
   assign dbgState = state;

`ifdef YMR_PREFETCH_EN
   logic [WORD_W-1:0] nextBuf;
   logic              nextValid;
   logic              pfIssued;
   logic              pfPending;
   logic [ROW_W:0]    lanesLeft;

   // Elements still sitting in the current word, including the one on the output.
   assign lanesLeft = (ROW_W+1)'(1 << LANE_LOG2) - {{(ROW_W+1-LANE_LOG2){1'b0}}, lane};
   assign pfRead    = (state == UNPACK) && !pfIssued && (remaining > lanesLeft);
`else
   assign pfRead    = 1'b0;
`endif

   always_comb begin
      sram_rd_en = 1'b0;
      sram_addr  = '0;
      if (state == READ) begin
         sram_rd_en = 1'b1;
         sram_addr  = addr;
      end else if (pfRead) begin
         sram_rd_en = 1'b1;
         sram_addr  = addr + 1'b1;
      end
   end

   always_comb begin
      out_valid = (state == UNPACK);
      out_row   = '0;
      out_data  = '0;
      if (out_valid) begin
         out_row  = {addr, lane};
         out_data = wordBuf[lane*ELEM_W +: ELEM_W];
      end
      busy = (state == READ) || (state == WAIT) || (state == UNPACK);
      done = (state == DONE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         addr      <= '0;
         lane      <= '0;
         remaining <= '0;
         wordBuf   <= '0;
`ifdef YMR_PREFETCH_EN
         nextBuf   <= '0;
         nextValid <= 1'b0;
         pfIssued  <= 1'b0;
         pfPending <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (row_count == '0) begin
                     state <= DONE;
                  end else begin
                     addr      <= row_start[ROW_W-1:LANE_LOG2];
                     lane      <= row_start[LANE_LOG2-1:0];
                     remaining <= row_count;
                     state     <= READ;
                  end
               end
            end
            READ: state <= WAIT;
            WAIT: begin
               wordBuf <= sram_rdata;
               state   <= UNPACK;
            end
            UNPACK: begin
`ifdef YMR_PREFETCH_EN
               pfPending <= pfRead;
               if (pfRead) pfIssued <= 1'b1;
               if (pfPending) begin
                  nextBuf   <= sram_rdata;
                  nextValid <= 1'b1;
               end
`endif
               if (accept) begin
                  remaining <= remaining - 1'b1;
                  if (lastElem) begin
                     state <= DONE;
                  end else if (lastLane) begin
                     lane <= '0;
                     addr <= addr + 1'b1;
`ifdef YMR_PREFETCH_EN
                     // Next word is buffered, arriving now, or was only just requested.
                     pfIssued  <= 1'b0;
                     pfPending <= 1'b0;
                     nextValid <= 1'b0;
                     if (nextValid) wordBuf <= nextBuf;
                     else if (pfPending) wordBuf <= sram_rdata;
                     else state <= WAIT;
`else
                     state <= READ;
`endif
                  end else begin
                     lane <= lane + 1'b1;
                  end
               end
            end
            DONE: begin
`ifdef YMR_PREFETCH_EN
               nextValid <= 1'b0;
               pfIssued  <= 1'b0;
               pfPending <= 1'b0;
`endif
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
